// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the serial UART receiver.
//   rx_state_e       receiver FSM state encoding
//   MIN_CLKS_PER_BIT smallest usable oversampling ratio
//   rx_err_t         per-frame error pulse bundle
package uart_rx_pkg;

  localparam int MIN_CLKS_PER_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  typedef struct packed {
    logic frame;
    logic parity;
    logic brk;
    logic overflow;
  } rx_err_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous show-ahead FIFO for received bytes.
//   clk, rst_n  clock and synchronous active-low reset (empties the FIFO)
//   push_i      write data_i; accepted when not full, or when full with a pop
//               in the same cycle
//   pop_i       remove the head entry; ignored while empty
//   data_o      head entry, forced to 0 while empty
//   full_o      occupancy equals DEPTH
//   empty_o     occupancy is zero
//   level_o     current occupancy
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees the head slot in the same edge, so a full FIFO can still accept.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/uart_serial_rx.sv
// uart_serial_rx: 8-bit UART line receiver (optional parity) with output FIFO.
//   clk, rst_n    clock and synchronous active-low reset
//   rx_i          asynchronous serial line, idles high
//   rx_en_i       receiver enable; low aborts any frame in progress
//   data_o        head-of-FIFO byte (show-ahead), valid_o = FIFO not empty
//   ready_i       pops the head when valid_o is high
//   frame_err_o   pulse: stop bit sampled low
//   parity_err_o  pulse: parity mismatch
//   break_o       pulse: framing error with all-zero data (and parity) bits
//   overflow_o    pulse: good byte dropped because the FIFO was full
//   fifo_lvl_o    FIFO occupancy
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for a low level on the synchronized line
// START      | half-bit wait, then confirm the start bit is still low
// DATA       | sampling 8 data bits LSB first, one per bit time
// PARITY     | sampling the parity bit and recording a mismatch
// STOP       | sampling the stop bit; push byte or report an error
// WAIT_IDLE  | after a framing error, wait for the line to return high
module uart_serial_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  input  logic                          rx_en_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          break_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic PAR_EN = (PARITY_EN != 0);
  localparam logic ODD    = (PARITY_ODD != 0);

  logic          sync1_q, sync2_q, rx_s;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_err_q, par_err_d;
  logic          par_bit_q, par_bit_d;
  rx_err_t       err_q, err_d;
  logic          push_req, fifo_full, fifo_empty, tick;

  assign rx_s = sync2_q;
  // The counter is loaded with the wait length and the sample is taken in
  // the cycle it reads 1, so a load of N samples exactly N cycles later.
  assign tick = (cnt_q == CW'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    par_bit_d = par_bit_q;
    push_req  = 1'b0;
    err_d     = '0;

    if (!rx_en_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            cnt_d   = CNT_HALF;
            state_d = ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              cnt_d     = CNT_FULL;
              bit_d     = '0;
              par_err_d = 1'b0;
              par_bit_d = 1'b0;
              state_d   = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_d = {rx_s, shift_q[7:1]};
            cnt_d   = CNT_FULL;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = PAR_EN ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            par_bit_d = rx_s;
            par_err_d = (((^shift_q) ^ rx_s) != ODD);
            cnt_d     = CNT_FULL;
            state_d   = ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (rx_s) begin
              if (par_err_q) err_d.parity = 1'b1;
              else           push_req     = 1'b1;
              state_d = ST_IDLE;
            end else begin
              err_d.frame = 1'b1;
              // par_bit_q stays 0 when parity is disabled
              err_d.brk   = (shift_q == 8'h00) && !par_bit_q;
              state_d     = ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    err_d.overflow = push_req & fifo_full & ~(valid_o & ready_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      par_bit_q <= 1'b0;
      err_q     <= '0;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      par_bit_q <= par_bit_d;
      err_q     <= err_d;
    end
  end

  assign frame_err_o  = err_q.frame;
  assign parity_err_o = err_q.parity;
  assign break_o      = err_q.brk;
  assign overflow_o   = err_q.overflow;
  assign valid_o      = ~fifo_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .data_i  (shift_q),
    .pop_i   (ready_i),
    .data_o  (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_lvl_o)
  );

endmodule

// File: tb/tb_uart_serial_rx.sv
// Bench for uart_serial_rx: two instances (8N1 and even parity), 16 clocks
// per bit. A frame-level model predicts each frame's outcome and the cycle it
// shows up, and mirrors the FIFO as a plain array; every cycle the outputs are
// compared against it, alongside hand-computed literal expectations.
module tb_uart_serial_rx;

  localparam int C = 16;
  localparam int H = C / 2;
  localparam int DEPTH = 4;
  localparam int K_GOOD = 0, K_PERR = 1, K_FERR = 2, K_FBRK = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_w [2];
  logic       en_w [2];
  logic       ready_w [2];
  logic [7:0] data_w [2];
  logic       valid_w [2];
  logic       fe_w [2];
  logic       pe_w [2];
  logic       brk_w [2];
  logic       ovf_w [2];
  logic [2:0] lvl_w [2];

  always #5 clk = ~clk;

  uart_serial_rx #(.CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_w[0]), .rx_en_i(en_w[0]),
    .data_o(data_w[0]), .valid_o(valid_w[0]), .ready_i(ready_w[0]),
    .frame_err_o(fe_w[0]), .parity_err_o(pe_w[0]), .break_o(brk_w[0]),
    .overflow_o(ovf_w[0]), .fifo_lvl_o(lvl_w[0]));

  uart_serial_rx #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_w[1]), .rx_en_i(en_w[1]),
    .data_o(data_w[1]), .valid_o(valid_w[1]), .ready_i(ready_w[1]),
    .frame_err_o(fe_w[1]), .parity_err_o(pe_w[1]), .break_o(brk_w[1]),
    .overflow_o(ovf_w[1]), .fifo_lvl_o(lvl_w[1]));

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  logic [7:0] mfifo [2][DEPTH];
  int         mcnt [2];
  logic       e_fe [2], e_pe [2], e_brk [2], e_ovf [2];
  int         ev_due [2];
  int         ev_kind [2];
  logic [7:0] ev_byte [2];
  int         c_fe [2], c_pe [2], c_brk [2], c_ovf [2];
  int         rise_cyc [2];
  logic       prev_v [2];

  task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, d, cyc, act, exp);
    end
  endtask

  function automatic int classify(logic [7:0] b, logic par, logic stop, int pen);
    if (!stop) return (b == 8'h00 && (pen == 0 || !par)) ? K_FBRK : K_FERR;
    if (pen != 0 && ((^b) ^ par)) return K_PERR;
    return K_GOOD;
  endfunction

  // Compare the current cycle, then advance the model across the next edge.
  task automatic tick();
    logic pop, push, full;
    for (int d = 0; d < 2; d++) begin
      if (chk_on) begin
        check("valid", d, valid_w[d], mcnt[d] > 0);
        if (mcnt[d] > 0) check("data", d, data_w[d], mfifo[d][0]);
        check("level", d, lvl_w[d], mcnt[d]);
        check("frame_err", d, fe_w[d], e_fe[d]);
        check("parity_err", d, pe_w[d], e_pe[d]);
        check("break", d, brk_w[d], e_brk[d]);
        check("overflow", d, ovf_w[d], e_ovf[d]);
        if (fe_w[d] === 1'b1) c_fe[d]++;
        if (pe_w[d] === 1'b1) c_pe[d]++;
        if (brk_w[d] === 1'b1) c_brk[d]++;
        if (ovf_w[d] === 1'b1) c_ovf[d]++;
        if (valid_w[d] === 1'b1 && prev_v[d] !== 1'b1) rise_cyc[d] = cyc;
        prev_v[d] = valid_w[d];
      end
      e_fe[d] = 1'b0; e_pe[d] = 1'b0; e_brk[d] = 1'b0; e_ovf[d] = 1'b0;
      if (rst_n !== 1'b1) begin
        mcnt[d] = 0;
      end else begin
        pop  = ready_w[d] && mcnt[d] > 0;
        full = (mcnt[d] == DEPTH);
        push = 1'b0;
        if (ev_due[d] == cyc + 1) begin
          case (ev_kind[d])
            K_GOOD: if (!full || pop) push = 1'b1; else e_ovf[d] = 1'b1;
            K_PERR: e_pe[d] = 1'b1;
            K_FERR: e_fe[d] = 1'b1;
            default: begin e_fe[d] = 1'b1; e_brk[d] = 1'b1; end
          endcase
        end
        if (pop) begin
          for (int i = 0; i < DEPTH - 1; i++) mfifo[d][i] = mfifo[d][i+1];
          mcnt[d]--;
        end
        if (push) begin
          mfifo[d][mcnt[d]] = ev_byte[d];
          mcnt[d]++;
        end
      end
    end
  endtask

  task automatic wait_cycles(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick();
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  // Frame bits: start, 8 data LSB first, [parity], stop. dis_at >= 0 drops
  // rx_en before that bit index and the frame is expected to vanish.
  task automatic send_frame(int d, logic [7:0] b, logic par, logic stop, int dis_at);
    logic [10:0] bits;
    int nb, pen;
    pen = (d == 1) ? 1 : 0;
    if (pen != 0) begin bits = {stop, par, b, 1'b0}; nb = 11; end
    else          begin bits = {1'b1, stop, b, 1'b0}; nb = 10; end
    if (dis_at < 0) begin
      ev_due[d]  = cyc + 2 + H + (9 + pen) * C + 1;
      ev_kind[d] = classify(b, par, stop, pen);
      ev_byte[d] = b;
    end
    for (int k = 0; k < nb; k++) begin
      if (k == dis_at) en_w[d] = 1'b0;
      rx_w[d] = bits[k];
      wait_cycles(C);
    end
    rx_w[d] = 1'b1;
  endtask

  task automatic pop(int d);
    ready_w[d] = 1'b1;
    wait_cycles(1);
    ready_w[d] = 1'b0;
  endtask

  function automatic int errsum(int d);
    return c_fe[d] + c_pe[d] + c_brk[d] + c_ovf[d];
  endfunction

  initial begin
    int n0, base, base_fe, base_brk, base_pe, base_ovf;
    for (int d = 0; d < 2; d++) begin
      rx_w[d] = 1'b1; en_w[d] = 1'b1; ready_w[d] = 1'b0;
      mcnt[d] = 0; ev_due[d] = -1; ev_kind[d] = K_GOOD; ev_byte[d] = 8'h00;
      e_fe[d] = 1'b0; e_pe[d] = 1'b0; e_brk[d] = 1'b0; e_ovf[d] = 1'b0;
      c_fe[d] = 0; c_pe[d] = 0; c_brk[d] = 0; c_ovf[d] = 0;
      rise_cyc[d] = -1; prev_v[d] = 1'b0;
      for (int i = 0; i < DEPTH; i++) mfifo[d][i] = 8'h00;
    end
    @(posedge clk); #1;
    wait_cycles(3);
    rst_n = 1'b1;
    chk_on = 1'b1;

    check("rst_valid", 0, valid_w[0], 0);
    check("rst_data", 0, data_w[0], 0);
    check("rst_level", 0, lvl_w[0], 0);

    // single byte: valid rises 2 (sync) + 8 + 9*16 + 1 = 155 cycles after the edge
    n0 = cyc; base = errsum(0);
    send_frame(0, 8'h55, 1'b0, 1'b1, -1);
    wait_cycles(2);
    check("single_latency", 0, rise_cyc[0] - n0, 155);
    check("single_data", 0, data_w[0], 8'h55);
    check("single_noerr", 0, errsum(0) - base, 0);
    pop(0);

    // burst of 5 with no consumer: 4 kept, 5th overflows
    base_ovf = c_ovf[0];
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b1, -1);
    wait_cycles(4);
    check("burst_level", 0, lvl_w[0], 4);
    check("burst_ovf", 0, c_ovf[0] - base_ovf, 1);
    for (int i = 1; i <= 4; i++) begin
      check("burst_order", 0, data_w[0], i);
      pop(0);
    end
    check("burst_drained", 0, valid_w[0], 0);
    pop(0);

    // 5-cycle glitch
    base = errsum(0);
    rx_w[0] = 1'b0; wait_cycles(5); rx_w[0] = 1'b1; wait_cycles(30);
    check("glitch_valid", 0, valid_w[0], 0);
    check("glitch_noerr", 0, errsum(0) - base, 0);

    // framing error, stop bit low
    base_fe = c_fe[0]; base_brk = c_brk[0];
    send_frame(0, 8'hA3, 1'b0, 1'b0, -1);
    wait_cycles(20);
    check("ferr_count", 0, c_fe[0] - base_fe, 1);
    check("ferr_nobrk", 0, c_brk[0] - base_brk, 0);
    check("ferr_nopush", 0, valid_w[0], 0);

    // break: line low for 12 bit times
    base_fe = c_fe[0]; base_brk = c_brk[0];
    ev_due[0] = cyc + 2 + H + 9 * C + 1; ev_kind[0] = K_FBRK; ev_byte[0] = 8'h00;
    rx_w[0] = 1'b0; wait_cycles(12 * C); rx_w[0] = 1'b1; wait_cycles(40);
    check("brk_ferr", 0, c_fe[0] - base_fe, 1);
    check("brk_count", 0, c_brk[0] - base_brk, 1);

    // even parity: 0x07 has three ones, parity bit 1 is correct
    base_pe = c_pe[1];
    send_frame(1, 8'h07, 1'b1, 1'b1, -1);
    wait_cycles(2);
    check("par_ok_valid", 1, valid_w[1], 1);
    check("par_ok_data", 1, data_w[1], 8'h07);
    pop(1);
    send_frame(1, 8'h07, 1'b0, 1'b1, -1);
    wait_cycles(4);
    check("par_err_count", 1, c_pe[1] - base_pe, 1);
    check("par_err_nopush", 1, valid_w[1], 0);

    // disable mid-DATA, then a clean frame
    base = errsum(0);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 5);
    wait_cycles(4); en_w[0] = 1'b1; wait_cycles(4);
    check("dis_valid", 0, valid_w[0], 0);
    check("dis_noerr", 0, errsum(0) - base, 0);
    send_frame(0, 8'h5A, 1'b0, 1'b1, -1);
    wait_cycles(2);
    check("dis_next_data", 0, data_w[0], 8'h5A);
    check("dis_next_level", 0, lvl_w[0], 1);

    // reset with two bytes buffered
    send_frame(0, 8'h11, 1'b0, 1'b1, -1);
    wait_cycles(2);
    check("pre_rst_level", 0, lvl_w[0], 2);
    rst_n = 1'b0;
    wait_cycles(1);
    check("rst2_valid", 0, valid_w[0], 0);
    check("rst2_level", 0, lvl_w[0], 0);
    rst_n = 1'b1;
    wait_cycles(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_serial_rx.md
# uart_serial_rx

Serial UART line receiver that turns the asynchronous `uart_tx` pin of the Ibex+UART top into a byte stream. It replaces the bus-snooping console in simulation benches with decoding of the real serial line, and is reusable as an on-chip receive front end. It handles 8N1, with optional parity, at a fixed clocks-per-bit rate. Decoded bytes are buffered in a small FIFO with a valid/ready output.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200); minimum 4.
- `PARITY_EN`, default 0: when 1, a parity bit follows the data bits.
- `PARITY_ODD`, default 0: selects odd parity when 1, even parity when 0.
- `FIFO_DEPTH`, default 4: number of byte entries in the output FIFO; power of two, at least 2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_i`  in  1  asynchronous serial input; idles high.
- `rx_en_i`  in  1  receiver enable.
- `data_o`  out  8  head-of-FIFO byte.
- `valid_o`  out  1  FIFO not empty.
- `ready_i`  in  1  consumer pops the head when `valid_o & ready_i`.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err_o`  out  1  one-cycle pulse: parity mismatch.
- `break_o`  out  1  one-cycle pulse: framing error with all data bits 0 and parity bit (if enabled) 0.
- `overflow_o`  out  1  one-cycle pulse: good byte dropped because the FIFO was full.
- `fifo_lvl_o`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Input synchronizer.** `rx_i` passes through a 2-flop synchronizer reset to 1, giving `rx_s`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- **IDLE.**
  - If `rx_en_i` and `rx_s`==0: load the bit counter with H = CLKS_PER_BIT/2 (floor) and go to START.
- **START.** When the counter expires, sample `rx_s`.
  - `rx_s`==1: glitch; return to IDLE with no output and no error.
  - `rx_s`==0: go to DATA with the counter reloaded to CLKS_PER_BIT.
- **DATA.** Samples 8 bits, LSB first, one per counter expiry, shifted into the shift register.
  - After bit 7, go to PARITY if `PARITY_EN`, otherwise to STOP.
- **PARITY.** Sample the parity bit.
  - Mismatch is computed as (XOR of data ^ bit) != `PARITY_ODD`.
  - Record the mismatch and go to STOP.
- **STOP.** Sample the stop bit.
  - **1, no parity error:** push the byte to the FIFO; return to IDLE.
  - **1, parity error:** pulse `parity_err_o`; drop the byte; return to IDLE.
  - **0:** pulse `frame_err_o`, plus `break_o` if the break condition holds; drop the byte; go to WAIT_IDLE.
- **WAIT_IDLE.** Stay until `rx_s`==1, then go to IDLE.
- **Push to a full FIFO.**
  - Without a simultaneous pop: pulse `overflow_o`, drop the byte, leave the FIFO contents unchanged.
  - With a simultaneous pop (`valid_o & ready_i` in the same cycle): the push succeeds and `overflow_o` stays 0.
- **Disable.** `rx_en_i` low in any state forces IDLE on the next cycle and aborts the partial frame silently. FIFO contents are retained and remain poppable.
- **Pop on empty.** `ready_i` while the FIFO is empty has no effect.
- **Reset.**
  - FSM goes to IDLE; FIFO is emptied; synchronizer flops are set to 1.
  - All outputs are 0, including `data_o`=0 and `fifo_lvl_o`=0.

## Timing
- **Reference cycle t0.** t0 is the first cycle IDLE sees `rx_s`==0; this is 2–3 cycles after the falling edge on `rx_i`.
- **Sample points:**
  - start bit at t0+H;
  - data bit i at t0+H+(i+1)·CLKS_PER_BIT;
  - parity bit at t0+H+9·CLKS_PER_BIT;
  - stop bit at t0+H+(9+PARITY_EN)·CLKS_PER_BIT.
- **Output latency.**
  - `valid_o`/`data_o` update in the cycle after the stop-bit sample.
  - Error pulses are asserted in that same cycle.
- **Back-to-back frames.** IDLE may detect the next start bit in the cycle immediately after the stop sample, so a half-bit stop is tolerated.
- **FIFO read.** Show-ahead: `data_o` is valid combinationally from the FIFO head whenever `valid_o` is high.
- **Occupancy.** `fifo_lvl_o` updates one cycle after the push/pop edge.

## Structure
- **Package `uart_rx_pkg`:** `rx_state_e` enum, the `MIN_CLKS_PER_BIT` constant, and the `rx_err_t` struct {frame, parity, brk, overflow}.
- **Bit counter width:** $clog2(CLKS_PER_BIT+1).
- **Sub-module:** `uart_rx_fifo`, a synchronous show-ahead FIFO with push/pop/full/empty/level. It is instantiated once.
- **Top module:** holds the synchronizer, FSM, counter, shift register, parity logic and error pulse generation.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- **Single byte.** Drive 0x55 in 8N1 → `valid_o` rises at t0+8+9·16+1; `data_o`=0x55; no error pulses.
- **Burst and backpressure.** Send 5 bytes 0x01..0x05 with `ready_i`=0 and FIFO_DEPTH=4 → `fifo_lvl_o`=4 and one `overflow_o` pulse on the 5th byte; then pop → 0x01..0x04 in order.
- **Glitch rejection.** Hold `rx_i` low for 5 cycles, then high → FSM returns to IDLE; no `valid_o`, no error pulses.
- **Framing error and break.**
  - Send 0xA3 with the stop bit low → `frame_err_o` pulse, no push, FSM waits in WAIT_IDLE.
  - Hold the line low for 12 bit-times → `frame_err_o` and `break_o` pulse together, once.
- **Parity.** With PARITY_EN=1 and PARITY_ODD=0, send 0x07 with parity bit 1 → accepted; send the same byte with parity bit 0 → `parity_err_o` pulse, no push.
- **Disable and reset.**
  - Deassert `rx_en_i` mid-DATA → no byte, no error; the following full frame decodes correctly.
  - Assert `rst_n`=0 with 2 bytes buffered → `valid_o`=0 and `fifo_lvl_o`=0 after the next clock edge.
